// File: rtl/even_or_odd.sv
// Parity classifier: registers even(1)/odd(0) one cycle after each accepted value.
// Optional saturating even/odd statistics counters with a synchronous clear are built only when EVEN_OR_ODD_STATS_EN is defined.
module even_or_odd #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] number,
  input  logic             in_valid,
  input  logic             clear,
  output logic             even_odd,
  output logic             out_valid,
  output logic [CNT_W-1:0] even_count,
  output logic [CNT_W-1:0] odd_count
);

  logic is_even;
  logic even_odd_q;
  logic out_valid_q;
  logic unused_number_bits;

  assign is_even            = ~number[0];
  // Only bit 0 decides parity; the upper bits are deliberately unused.
  assign unused_number_bits = ^number;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      even_odd_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) even_odd_q <= is_even;
    end
  end

  assign even_odd  = even_odd_q;
  assign out_valid = out_valid_q;

`ifdef EVEN_OR_ODD_STATS_EN
  logic [CNT_W-1:0] even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0] odd_cnt_q,  odd_cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    even_cnt_d = even_cnt_q;
    odd_cnt_d  = odd_cnt_q;
    if (clear) begin
      even_cnt_d = '0;
      odd_cnt_d  = '0;
    end else if (in_valid) begin
      if (is_even) begin
        if (even_cnt_q != '1) even_cnt_d = even_cnt_q + CNT_W'(1);
      end else begin
        if (odd_cnt_q != '1) odd_cnt_d = odd_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      even_cnt_q <= '0;
      odd_cnt_q  <= '0;
    end else begin
      even_cnt_q <= even_cnt_d;
      odd_cnt_q  <= odd_cnt_d;
    end
  end

  assign even_count = even_cnt_q;
  assign odd_count  = odd_cnt_q;
`else
  logic unused_clear;

  assign unused_clear = clear;
  assign even_count   = '0;
  assign odd_count    = '0;
`endif

endmodule

// File: tb/tb_even_or_odd.sv
// Randomized self-checking bench for even_or_odd: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream and are compared against an integer-count reference model.
module tb_even_or_odd;

`ifdef EVEN_OR_ODD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int WIDTH  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_WS = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] number;
  logic             in_valid;
  logic             clear;
  logic             even_odd,  out_valid;
  logic             even_odd_s, out_valid_s;
  logic [CNT_W-1:0]  even_count,  odd_count;
  logic [CNT_WS-1:0] even_count_s, odd_count_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: unbounded counts, saturation applied only when compared.
  int m_even, m_odd;
  bit m_eo, m_ov;

  even_or_odd #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .number(number), .in_valid(in_valid), .clear(clear),
    .even_odd(even_odd), .out_valid(out_valid),
    .even_count(even_count), .odd_count(odd_count)
  );

  even_or_odd #(.WIDTH(WIDTH), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst(rst), .number(number), .in_valid(in_valid), .clear(clear),
    .even_odd(even_odd_s), .out_valid(out_valid_s),
    .even_count(even_count_s), .odd_count(odd_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (c > lim) ? lim : c;
  endfunction

  function automatic int exp_cnt(input int c, input int w);
    return STATS ? sat(c, w) : 0;
  endfunction

  task automatic model_reset();
    m_even = 0; m_odd = 0; m_eo = 1'b0; m_ov = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".even_odd"},    32'(even_odd),     32'(m_eo));
    check({tag, ".out_valid"},   32'(out_valid),    32'(m_ov));
    check({tag, ".even_count"},  32'(even_count),   32'(exp_cnt(m_even, CNT_W)));
    check({tag, ".odd_count"},   32'(odd_count),    32'(exp_cnt(m_odd,  CNT_W)));
    check({tag, ".s_even_odd"},  32'(even_odd_s),   32'(m_eo));
    check({tag, ".s_out_valid"}, 32'(out_valid_s),  32'(m_ov));
    check({tag, ".s_even_cnt"},  32'(even_count_s), 32'(exp_cnt(m_even, CNT_WS)));
    check({tag, ".s_odd_cnt"},   32'(odd_count_s),  32'(exp_cnt(m_odd,  CNT_WS)));
  endtask

  // One clock edge: update the model from the inputs in force at the edge, then check.
  task automatic cycle(input string tag);
    bit v_even;
    @(posedge clk);
    v_even = (number % 2) == 0;
    m_ov = in_valid;
    if (in_valid) m_eo = v_even;
    if (STATS) begin
      if (clear) begin
        m_even = 0; m_odd = 0;
      end else if (in_valid) begin
        if (v_even) m_even++; else m_odd++;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] n, input logic c);
    in_valid = v; number = n; clear = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Full 0..15 sweep, back to back.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      cycle("sweep");
    end
    check("sweep_even_total", 32'(even_count), STATS ? 32'd8 : 32'd0);
    check("sweep_odd_total",  32'(odd_count),  STATS ? 32'd8 : 32'd0);

    // Idle after an odd value: result holds, out_valid drops.
    drive(1'b1, 4'd7, 1'b0);
    cycle("accept7");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, WIDTH'($urandom_range(0, 15)), 1'b0);
      cycle("idle");
      check("idle_hold_odd", 32'(even_odd), 32'd0);
    end

    // Clear and accept on the same edge.
    drive(1'b1, 4'd4, 1'b1);
    cycle("clear_accept");
    check("clear_even_odd", 32'(even_odd), 32'd1);
    check("clear_even_cnt", 32'(even_count), 32'd0);
    check("clear_odd_cnt",  32'(odd_count),  32'd0);

    // Five even values: 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, WIDTH'(2 * $urandom_range(0, 7)), 1'b0);
      cycle("sat");
    end
    check("sat_small_even", 32'(even_count_s), STATS ? 32'd3 : 32'd0);
    check("sat_small_odd",  32'(odd_count_s),  32'd0);

    // Random traffic, with an occasional clear.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom_range(0, 15) == 0));
      cycle("rand");
    end

    // Asynchronous reset mid-stream with a value pending.
    drive(1'b1, 4'd3, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #2 rst = 1'b0;
    drive(1'b1, 4'd9, 1'b0);
    cycle("post_rst9");
    check("post_rst_even_odd", 32'(even_odd), 32'd0);
    check("post_rst_odd_cnt",  32'(odd_count), STATS ? 32'd1 : 32'd0);
    drive(1'b0, '0, 1'b0);
    cycle("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
